priority_scheduler: RTL and testbench
=====================================

// Module: priority_scheduler
// PURPOSE
// - Generates the four 2-bit priorities consumed by the intersection:
//   pedestrian, up, down and turn.
// - Grants one phase at a time to the intersection over a valid/ack/done handshake.
// - Demotes the served phase to lowest priority and shifts the others up (LRU order).
// - Outputs always form a permutation of {0,1,2,3}. 3 is the highest priority.
// PARAMETERS
// - CLEAR_CYCLES  2   all-red idle cycles enforced after phase_done before the next grant (>=1)
// - STARVE_LIMIT  3   grants a requester may be passed over before it is forced (PRIO_AGING_EN only)
// PORTS
// - clock                in   1  single clock, rising edge
// - reset                in   1  asynchronous, active-high
// - req                  in   4  phase requests; bit0 ped, bit1 up, bit2 down, bit3 turn
// - grant_valid          out  1  grant offered to intersection
// - grant_id             out  2  phase being offered/served; stable while grant_valid or ACTIVE
// - grant_ack            in   1  intersection accepts the offered grant
// - phase_done           in   1  intersection finished the active phase
// - priority_pedestrian  out  2  current priority of pedestrian phase
// - priority_up          out  2  current priority of up phase
// - priority_down        out  2  current priority of down phase
// - priority_turn        out  2  current priority of turn phase
// BEHAVIOUR
// - Reset (async, immediate, including mid-grant):
//   - state=CLEAR, clear counter=CLEAR_CYCLES-1
//   - grant_valid=0, grant_id=0
//   - priority ped=3, up=2, down=1, turn=0
//   - aging counters=0
// - FSM CLEAR: counter decrements each cycle; at 0 go to IDLE. req is ignored.
// - FSM IDLE: if req!=0, register grant_id = requesting phase with highest priority,
//   set grant_valid=1 and go to OFFER.
//   - Latency: req seen at edge N gives grant_valid=1 after edge N.
// - FSM OFFER: grant_valid and grant_id are held even if req drops.
//   - On grant_ack: grant_valid=0, go to ACTIVE.
// - FSM ACTIVE: on phase_done:
//   - priority[grant_id] becomes 0; every phase with an old priority below it increments by 1.
//   - Go to CLEAR with counter reloaded. Priorities update on that same edge.
// - Handshake signals outside their state are ignored:
//   - grant_ack outside OFFER
//   - phase_done outside ACTIVE
//   - phase_done in the ack cycle
// - The rotation preserves the permutation. Unserved phases never change relative order.
// - The priority outputs are registered and change only on the phase_done edge or reset.
// CONFIGURATION
// - PRIO_AGING_EN defined: each phase has a $clog2(STARVE_LIMIT+1)-bit skip counter.
//   - At the IDLE->OFFER edge, every requesting, non-selected phase increments its
//     counter (saturating); the selected phase clears to 0.
//   - Any phase with counter==STARVE_LIMIT and req=1 overrides priority selection.
//     The lowest index wins among such phases.
//   - The priority rotation is unchanged.
// - PRIO_AGING_EN undefined: no counters; selection is pure priority.
// STRUCTURE
// - Package priorities_pkg:
//   - phase_e enum: PED=0, UP=1, DOWN=2, TURN=3
//   - prio_t = logic [1:0]
//   - sched_state_e: CLEAR, IDLE, OFFER, ACTIVE
//   - reset priority constants
// - Sub-module priority_rotator (combinational): current prio_t[4] and served id in,
//   next prio_t[4] out. Also used by the bench as its reference model.
// - The existing priorities checker binds onto this block unchanged.
// TESTING
// - Reset, then hold req=4'b0110 -> after CLEAR, grant_id=1 (up, prio 2 beats down prio 1).
// - Ack, then phase_done for id1 -> priorities ped=3, up=0, down=2, turn=1;
//   the next grant is at least CLEAR_CYCLES idle cycles later.
// - Offer id0, drop req before grant_ack -> grant_valid stays 1 and grant_id stays 0 until ack.
// - phase_done pulsed in IDLE/OFFER, and grant_ack in ACTIVE -> no state or priority change.
// - Assert reset while in ACTIVE -> grant_valid=0 and priorities 3/2/1/0 immediately, before the clock.
// - With PRIO_AGING_EN and STARVE_LIMIT=3, keep req=4'b1001 for many grants:
//   - turn is served at least once every 4 grants.
//   - Without the macro, ped/turn alternate via rotation.
// - All tests: the permutation check holds every cycle out of reset.

Source files
------------

// File: rtl/priorities_pkg.sv
// Shared types and constants for the priority scheduler: phase ids, priority
// encoding, scheduler states and the reset priority order.
package priorities_pkg;

  typedef enum logic [1:0] {
    PED  = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    TURN = 2'd3
  } phase_e;

  typedef logic [1:0] prio_t;
  typedef prio_t [3:0] prio_vec_t;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    OFFER,
    ACTIVE
  } sched_state_e;

  localparam prio_t RESET_PRIO_PED  = 2'd3;
  localparam prio_t RESET_PRIO_UP   = 2'd2;
  localparam prio_t RESET_PRIO_DOWN = 2'd1;
  localparam prio_t RESET_PRIO_TURN = 2'd0;

  localparam prio_vec_t RESET_PRIO = {RESET_PRIO_TURN, RESET_PRIO_DOWN,
                                      RESET_PRIO_UP, RESET_PRIO_PED};

  // Returns the requesting phase with the highest priority; PED if none request.
  function automatic phase_e pick_highest(input logic [3:0] req, input prio_vec_t prio);
    phase_e best;
    prio_t  bestPrio;
    logic   found;
    best     = PED;
    bestPrio = '0;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (!found || prio[i] > bestPrio)) begin
        best     = phase_e'(2'(i));
        bestPrio = prio[i];
        found    = 1'b1;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/priority_rotator.sv
// Combinational LRU rotation: the served phase drops to priority 0 and every
// phase that ranked below it moves up by one, so the set stays a permutation.
module priority_rotator
  import priorities_pkg::*;
(
  input  prio_vec_t prio_i,
  input  phase_e    served_i,
  output prio_vec_t prio_o
);

  prio_t servedPrio;

  assign servedPrio = prio_i[served_i];

  always_comb begin
    prio_o = prio_i;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == served_i) begin
        prio_o[i] = '0;
      end else if (prio_i[i] < servedPrio) begin
        prio_o[i] = prio_i[i] + 2'd1;
      end
    end
  end

endmodule

// File: rtl/priority_scheduler.sv
// Phase scheduler granting one intersection phase at a time with LRU priorities.
// Optional starvation aging is enabled by defining PRIO_AGING_EN.
module priority_scheduler
  import priorities_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2
`ifdef PRIO_AGING_EN
  ,
  parameter int unsigned STARVE_LIMIT = 3
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  input  logic       grant_ack,
  input  logic       phase_done,
  output logic [1:0] priority_pedestrian,
  output logic [1:0] priority_up,
  output logic [1:0] priority_down,
  output logic [1:0] priority_turn
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CLEAR_RELOAD = CNT_W'(CLEAR_CYCLES - 1);

  sched_state_e     state_q;
  logic [CNT_W-1:0] clearCnt_q;
  logic             grantValid_q;
  phase_e           grantId_q;
  prio_vec_t        prio_q;

  phase_e           selId_d;
  prio_vec_t        prio_d;

  priority_rotator u_rotator (
    .prio_i   (prio_q),
    .served_i (grantId_q),
    .prio_o   (prio_d)
  );

`ifdef PRIO_AGING_EN
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] ageCnt_q [4];
  logic             forced;
  phase_e           forcedId;

  // A starved requester overrides priority; scanning downward leaves the lowest index.
  always_comb begin
    forced   = 1'b0;
    forcedId = PED;
    for (int i = 3; i >= 0; i--) begin
      if (req[i] && ageCnt_q[i] == AGE_MAX) begin
        forced   = 1'b1;
        forcedId = phase_e'(2'(i));
      end
    end
  end

  assign selId_d = forced ? forcedId : pick_highest(req, prio_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) ageCnt_q[i] <= '0;
    end else if (state_q == IDLE && req != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == selId_d) begin
          ageCnt_q[i] <= '0;
        end else if (req[i] && ageCnt_q[i] != AGE_MAX) begin
          ageCnt_q[i] <= ageCnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  assign selId_d = pick_highest(req, prio_q);
`endif

  // Handshake inputs only matter in their own state, so stray pulses fall through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clearCnt_q   <= CLEAR_RELOAD;
      grantValid_q <= 1'b0;
      grantId_q    <= PED;
      prio_q       <= RESET_PRIO;
    end else begin
      unique case (state_q)
        CLEAR: begin
          if (clearCnt_q == '0) state_q <= IDLE;
          else clearCnt_q <= clearCnt_q - 1'b1;
        end
        IDLE: begin
          if (req != 4'd0) begin
            grantId_q    <= selId_d;
            grantValid_q <= 1'b1;
            state_q      <= OFFER;
          end
        end
        OFFER: begin
          if (grant_ack) begin
            grantValid_q <= 1'b0;
            state_q      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (phase_done) begin
            prio_q     <= prio_d;
            clearCnt_q <= CLEAR_RELOAD;
            state_q    <= CLEAR;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign grant_valid         = grantValid_q;
  assign grant_id            = grantId_q;
  assign priority_pedestrian = prio_q[PED];
  assign priority_up         = prio_q[UP];
  assign priority_down       = prio_q[DOWN];
  assign priority_turn       = prio_q[TURN];

endmodule

// File: tb/tb_priority_scheduler.sv
// Self-checking bench for priority_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against an LRU-queue reference model.
module tb_priority_scheduler;

  localparam int CLEAR_CYCLES = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'd0;
  logic       grantAck = 1'b0;
  logic       phaseDone = 1'b0;
  logic       grantValid;
  logic [1:0] grantId;
  logic [1:0] prioPed, prioUp, prioDown, prioTurn;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  priority_scheduler #(.CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clock               (clock),
    .reset               (reset),
    .req                 (req),
    .grant_valid         (grantValid),
    .grant_id            (grantId),
    .grant_ack           (grantAck),
    .phase_done          (phaseDone),
    .priority_pedestrian (prioPed),
    .priority_up         (prioUp),
    .priority_down       (prioDown),
    .priority_turn       (prioTurn)
  );

  // Reference model: lru holds phase ids from highest to lowest priority.
  int lru[$];
  int mMode;
  int mClearLeft;
  bit mValid;
  int mId;

  function automatic int modelPrio(int ph);
    for (int k = 0; k < lru.size(); k++) if (lru[k] == ph) return 3 - k;
    return -1;
  endfunction

  task automatic modelReset();
    lru = '{0, 1, 2, 3};
    mMode = 0;
    mClearLeft = CLEAR_CYCLES;
    mValid = 1'b0;
    mId = 0;
  endtask

  task automatic modelStep(input logic [3:0] r, input logic a, input logic d);
    bit found;
    int pos;
    case (mMode)
      0: begin
        mClearLeft--;
        if (mClearLeft == 0) mMode = 1;
      end
      1: if (r != 4'd0) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!found && r[lru[k]]) begin
            mId = lru[k];
            found = 1'b1;
          end
        end
        mValid = 1'b1;
        mMode = 2;
      end
      2: if (a) begin
        mValid = 1'b0;
        mMode = 3;
      end
      3: if (d) begin
        pos = 0;
        for (int k = 0; k < lru.size(); k++) if (lru[k] == mId) pos = k;
        lru.delete(pos);
        lru.push_back(mId);
        mMode = 0;
        mClearLeft = CLEAR_CYCLES;
      end
      default: mMode = 0;
    endcase
  endtask

  task automatic checkVal(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] seen;
    checkVal("model valid", {7'd0, grantValid}, {7'd0, mValid});
    checkVal("model id", {6'd0, grantId}, 8'(mId));
    checkVal("model prio ped", {6'd0, prioPed}, 8'(modelPrio(0)));
    checkVal("model prio up", {6'd0, prioUp}, 8'(modelPrio(1)));
    checkVal("model prio down", {6'd0, prioDown}, 8'(modelPrio(2)));
    checkVal("model prio turn", {6'd0, prioTurn}, 8'(modelPrio(3)));
    seen = 4'd0;
    seen[prioPed] = 1'b1;
    seen[prioUp] = 1'b1;
    seen[prioDown] = 1'b1;
    seen[prioTurn] = 1'b1;
    checkVal("permutation", {4'd0, seen}, 8'hF);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic a, input logic d);
    req = r;
    grantAck = a;
    phaseDone = d;
    @(posedge clock);
    modelStep(r, a, d);
    @(negedge clock);
    checkOutput();
  endtask

  task automatic doReset();
    req = 4'd0;
    grantAck = 1'b0;
    phaseDone = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    checkOutput();
  endtask

  task automatic checkPrios(input string name, input logic [7:0] exp);
    checkVal(name, {prioTurn, prioDown, prioUp, prioPed}, exp);
  endtask

  // Packs expected priorities as {turn, down, up, ped}.
  function automatic logic [7:0] P(input int ped, input int up, input int down, input int turn);
    return {2'(turn), 2'(down), 2'(up), 2'(ped)};
  endfunction

  task automatic waitGrant(input logic [3:0] r, output bit ok);
    int budget;
    budget = 0;
    while (!grantValid && budget < 12) begin
      applyStimulus(r, 1'b0, 1'b0);
      budget++;
    end
    ok = grantValid;
    if (!ok) checkVal("grant timeout", 8'd0, 8'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       done;
    logic       expValid;
    logic [1:0] expId;
    logic [7:0] expPrio;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit ok;
    int sinceTurn;
    int expId;

    tbl[0]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, P(3, 2, 1, 0)};
    tbl[1]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd0, P(3, 2, 1, 0)};
    tbl[2]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd1, P(3, 2, 1, 0)};
    tbl[3]  = '{4'b0110, 1'b1, 1'b0, 1'b0, 2'd1, P(3, 2, 1, 0)};
    tbl[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, P(3, 0, 2, 1)};
    tbl[5]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd1, P(3, 0, 2, 1)};
    tbl[6]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd1, P(3, 0, 2, 1)};
    tbl[7]  = '{4'b0110, 1'b0, 1'b0, 1'b1, 2'd2, P(3, 0, 2, 1)};
    tbl[8]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, P(3, 0, 2, 1)};
    tbl[9]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, P(3, 0, 2, 1)};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, P(3, 0, 2, 1)};
    tbl[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, P(3, 1, 0, 2)};

    doReset();
    checkVal("reset valid", {7'd0, grantValid}, 8'd0);
    checkVal("reset id", {6'd0, grantId}, 8'd0);
    checkPrios("reset prios", P(3, 2, 1, 0));

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].req, tbl[i].ack, tbl[i].done);
      checkVal($sformatf("vec%0d valid", i), {7'd0, grantValid}, {7'd0, tbl[i].expValid});
      checkVal($sformatf("vec%0d id", i), {6'd0, grantId}, {6'd0, tbl[i].expId});
      checkPrios($sformatf("vec%0d prios", i), tbl[i].expPrio);
    end

    // Offer ped, then drop req before the ack: the offer must hold.
    doReset();
    repeat (3) applyStimulus(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkVal("held valid", {7'd0, grantValid}, 8'd1);
      checkVal("held id", {6'd0, grantId}, 8'd0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkVal("ack drops valid", {7'd0, grantValid}, 8'd0);

    // Stray grant_ack while ACTIVE, then the real phase_done.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkPrios("ack in active", P(3, 2, 1, 0));
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkPrios("ped served", P(0, 3, 2, 1));
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b1);
    checkPrios("done in clear/idle", P(0, 3, 2, 1));
    checkVal("done in idle valid", {7'd0, grantValid}, 8'd0);

    // Reach ACTIVE with rotated priorities, then assert reset mid-cycle.
    waitGrant(4'b0100, ok);
    checkVal("down offered", {6'd0, grantId}, 8'd2);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkVal("async reset valid", {7'd0, grantValid}, 8'd0);
    checkVal("async reset id", {6'd0, grantId}, 8'd0);
    checkPrios("async reset prios", P(3, 2, 1, 0));
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    checkOutput();

    // Ped and turn requesting forever: rotation must alternate them.
    sinceTurn = 0;
    for (int g = 0; g < 8; g++) begin
      waitGrant(4'b1001, ok);
      if (!ok) break;
      expId = (g % 2 == 0) ? 0 : 3;
      checkVal($sformatf("alternate grant%0d", g), {6'd0, grantId}, 8'(expId));
      if (grantId == 2'd3) sinceTurn = 0;
      else sinceTurn++;
      checkVal("turn starvation", {7'd0, sinceTurn < 4}, 8'd1);
      applyStimulus(4'b1001, 1'b1, 1'b0);
      applyStimulus(4'b1001, 1'b0, 1'b1);
    end

    // Randomized traffic against the reference model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
